// File: rtl/slim_freeze_ctrl_pkg.sv
// Shared types and defaults for the slime freeze controller and its hit-box helper.
package slim_freeze_ctrl_pkg;

  localparam int unsigned X_W       = 10;
  localparam int unsigned Y_W       = 9;
  localparam int unsigned IPCNT_W   = 32;
  localparam int unsigned TIMER_W   = 7;
  localparam int unsigned HIT_CNT_W = 8;

  localparam int unsigned SLIM_W_DEF = 34;
  localparam int unsigned SLIM_H_DEF = 33;
  localparam logic [IPCNT_W-1:0] TICK_VAL_DEF = 32'd6_000_000;

  // Longest frozen span the renderer's frozen-frame counter can represent.
  localparam int unsigned FROZEN_SPAN_MAX = 126;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FROZEN = 2'd1,
    ST_THAW   = 2'd2
  } frz_state_t;

  function automatic logic [HIT_CNT_W-1:0] sat_inc(input logic [HIT_CNT_W-1:0] v);
    return (&v) ? v : v + HIT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/slim_freeze_ctrl_if.sv
// Projectile impact handshake between the shooter logic and the freeze controller.
interface slim_freeze_ctrl_if;
  import slim_freeze_ctrl_pkg::*;

  logic           shot_valid;
  logic [X_W-1:0] shot_x;
  logic [Y_W-1:0] shot_y;
  logic           shot_ack;
  logic           shot_hit;

  modport master (output shot_valid, shot_x, shot_y, input shot_ack, shot_hit);
  modport slave  (input shot_valid, shot_x, shot_y, output shot_ack, shot_hit);
endinterface

// File: rtl/slim_hit_box.sv
// Combinational point-in-rectangle test; upper bounds are widened one bit so they never wrap.
module slim_hit_box
  import slim_freeze_ctrl_pkg::*;
#(
  parameter int unsigned BOX_W = SLIM_W_DEF,
  parameter int unsigned BOX_H = SLIM_H_DEF
) (
  input  logic [X_W-1:0] box_x,
  input  logic [Y_W-1:0] box_y,
  input  logic [X_W-1:0] pt_x,
  input  logic [Y_W-1:0] pt_y,
  output logic           hit_c
);

  localparam int unsigned XE_W = X_W + 1;
  localparam int unsigned YE_W = Y_W + 1;

  logic [XE_W-1:0] x_hi;
  logic [YE_W-1:0] y_hi;

  assign x_hi = {1'b0, box_x} + XE_W'(BOX_W - 1);
  assign y_hi = {1'b0, box_y} + YE_W'(BOX_H - 1);

  assign hit_c = (pt_x >= box_x) && ({1'b0, pt_x} <= x_hi) &&
                 (pt_y >= box_y) && ({1'b0, pt_y} <= y_hi);

endmodule

// File: rtl/slim_freeze_ctrl.sv
// Freezes the slime on a projectile hit, holds it frozen, warns during thaw, then releases it.
module slim_freeze_ctrl
  import slim_freeze_ctrl_pkg::*;
#(
  parameter logic [IPCNT_W-1:0] TICK_VAL     = TICK_VAL_DEF,
  parameter int unsigned        FREEZE_TICKS = 100,
  parameter int unsigned        THAW_TICKS   = 20,
  parameter int unsigned        SLIM_W       = SLIM_W_DEF,
  parameter int unsigned        SLIM_H       = SLIM_H_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IPCNT_W-1:0]   ipcnt,
  input  logic [X_W-1:0]       x_slim,
  input  logic [Y_W-1:0]       y_slim,
  slim_freeze_ctrl_if.slave    shot,
  output logic                 slim_frozen,
  output logic                 thaw_warn,
  output logic [HIT_CNT_W-1:0] hit_cnt
);

  if (FREEZE_TICKS + THAW_TICKS > FROZEN_SPAN_MAX || FREEZE_TICKS == 0 || THAW_TICKS == 0) begin : g_bad_ticks
    $error("slim_freeze_ctrl: FREEZE_TICKS/THAW_TICKS out of range");
  end

  frz_state_t         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               shot_ack_q, shot_hit_q;
  logic               take_c, in_box_c, hit_c, tick_c;

  slim_hit_box #(
    .BOX_W (SLIM_W),
    .BOX_H (SLIM_H)
  ) u_hit_box (
    .box_x (x_slim),
    .box_y (y_slim),
    .pt_x  (shot.shot_x),
    .pt_y  (shot.shot_y),
    .hit_c (in_box_c)
  );

  // A held shot_valid is taken every other cycle: the ack cycle blocks resampling.
  assign take_c = shot.shot_valid & ~shot_ack_q;
  assign hit_c  = take_c & in_box_c;
  assign tick_c = (ipcnt == TICK_VAL);

  assign shot.shot_ack = shot_ack_q;
  assign shot.shot_hit = shot_hit_q;

  // Next state: a hit always (re)loads the freeze, otherwise ticks count the timer down.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (hit_c) begin
      state_d = ST_FROZEN;
      timer_d = TIMER_W'(FREEZE_TICKS);
    end else if (tick_c) begin
      unique case (state_q)
        ST_FROZEN: begin
          if (timer_q == TIMER_W'(1)) begin
            state_d = ST_THAW;
            timer_d = TIMER_W'(THAW_TICKS);
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        ST_THAW: begin
          if (timer_q == TIMER_W'(1)) begin
            state_d = ST_ACTIVE;
            timer_d = '0;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        default: begin
          state_d = ST_ACTIVE;
          timer_d = '0;
        end
      endcase
    end
  end

  // State, timer and registered outputs; outputs follow the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACTIVE;
      timer_q     <= '0;
      shot_ack_q  <= 1'b0;
      shot_hit_q  <= 1'b0;
      slim_frozen <= 1'b0;
      thaw_warn   <= 1'b0;
      hit_cnt     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      shot_ack_q  <= take_c;
      shot_hit_q  <= hit_c;
      slim_frozen <= (state_d != ST_ACTIVE);
      thaw_warn   <= (state_d == ST_THAW);
      if (hit_c) begin
        hit_cnt <= sat_inc(hit_cnt);
      end
    end
  end

endmodule
